lbm_stream_engine: RTL and testbench

- Parametrised, fully pipelined LBM streaming sequencer for one lattice direction (DX, DY).
- Reads every cell of a source population BRAM in raster order and writes it to the neighbour cell in the destination BRAM.
- Handles wrap or drop at grid edges. Performs in-stream half-way bounce-back into the reflected-direction BRAM when the target cell is a barrier.
- The solver top instantiates one per direction, replacing the hand-coded per-direction stream/bounce states.

---
 rtl/lbm_stream_engine.sv | 132 +++++++++++++
 tb/tb_lbm_stream_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lbm_stream_engine.sv
// lbm_stream_engine: streams one lattice direction between population BRAMs with edge wrap/drop and half-way bounce-back.
module lbm_stream_engine #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 8,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DX     = 1,
  parameter int DY     = 0,
  parameter int RD_LAT = 2,
  parameter int WRAP_X = 1,
  parameter int WRAP_Y = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH*HEIGHT-1:0] barriers,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       src_addr,
  output logic                    src_rd_en,
  input  logic [DATA_W-1:0]       src_data,
  output logic [ADDR_W-1:0]       dst_addr,
  output logic [DATA_W-1:0]       dst_data,
  output logic                    dst_we,
  output logic [ADDR_W-1:0]       refl_addr,
  output logic [DATA_W-1:0]       refl_data,
  output logic                    refl_we,
  output logic [15:0]             cells_written,
  output logic [15:0]             cells_reflected
);
  localparam logic [ADDR_W-1:0] XM = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] YM = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] NM = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WA = ADDR_W'(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic              v;
    logic              drop;
    logic              sbar;
    logic              tbar;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] tgt;
  } meta_t;
  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_x, r_y, r_idx, w_tx, w_ty;
  logic [2**ADDR_W-1:0] w_bar;
  logic                 w_xo, w_yo, w_last, w_empty, w_dst, w_refl;
  meta_t                r_pipe [RD_LAT+1];
  meta_t                w_issue, w_wr;
  // Stage 0 is the issue register driving the BRAM; the last stage lines up with src_data.
  always_comb begin
    w_bar = '0;
    w_bar[WIDTH*HEIGHT-1:0] = barriers;
    w_xo = (DX == 1 && r_x == XM) || (DX == -1 && r_x == '0);
    w_yo = (DY == 1 && r_y == YM) || (DY == -1 && r_y == '0);
    w_tx = (DX == 1) ? (w_xo ? '0 : r_x + 1'b1) : (DX == -1) ? (w_xo ? XM : r_x - 1'b1) : r_x;
    w_ty = (DY == 1) ? (w_yo ? '0 : r_y + 1'b1) : (DY == -1) ? (w_yo ? YM : r_y - 1'b1) : r_y;
    w_last = r_idx == NM;
    w_issue.v = r_state == S_RUN;
    w_issue.drop = (w_xo && WRAP_X == 0) || (w_yo && WRAP_Y == 0);
    w_issue.src = r_idx;
    w_issue.tgt = w_ty * WA + w_tx;
    w_issue.sbar = w_bar[r_idx];
    w_issue.tbar = w_bar[w_issue.tgt];
    w_wr = r_pipe[RD_LAT];
    w_dst = w_wr.v && !w_wr.sbar && !w_wr.drop && !w_wr.tbar;
    w_refl = w_wr.v && !w_wr.sbar && !w_wr.drop && w_wr.tbar;
    w_empty = 1'b1;
    for (int i = 0; i <= RD_LAT; i++) w_empty &= ~r_pipe[i].v;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
      r_idx <= '0;
      for (int i = 0; i <= RD_LAT; i++) r_pipe[i] <= '0;
      dst_we <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
      refl_we <= 1'b0;
      refl_addr <= '0;
      refl_data <= '0;
      cells_written <= '0;
      cells_reflected <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_x <= '0;
        r_y <= '0;
        r_idx <= '0;
        cells_written <= '0;
        cells_reflected <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_x <= (r_x == XM) ? '0 : r_x + 1'b1;
          r_y <= (r_x == XM) ? ((r_y == YM) ? '0 : r_y + 1'b1) : r_y;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        if (w_dst) cells_written <= cells_written + 1'b1;
        if (w_refl) cells_reflected <= cells_reflected + 1'b1;
      end
      r_pipe[0] <= w_issue;
      for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      dst_we <= w_dst;
      refl_we <= w_refl;
      if (w_dst) begin
        dst_addr <= w_wr.tgt;
        dst_data <= src_data;
      end
      if (w_refl) begin
        refl_addr <= w_wr.src;
        refl_data <= src_data;
      end
    end
  end
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign src_rd_en = r_pipe[0].v;
  assign src_addr = r_pipe[0].src;
endmodule

// File: tb/tb_lbm_stream_engine.sv
// tb_lbm_stream_engine: directed checks of streaming, edge drop, bounce-back, ignored restart and mid-pass reset on a 4x3 grid.
module tb_lbm_stream_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st [3];
  logic [11:0] bar [3];
  logic        bz [3], dn [3], ren [3], dw [3], rw [3];
  logic [3:0]  sa [3], da [3], ra [3];
  logic [15:0] sd [3], d1 [3], dd [3], rd [3], cw [3], cr [3];
  logic [15:0] dhit, rhit;
  logic [15:0] dmem [16], rmem [16];
  int          n_cmp = 0, n_bad = 0;
  int          nw, ndone, tdone, tw0, both, b0, r1_en, r1_addr;
  always #5 clk = ~clk;
  // Source BRAM model: two-cycle read latency, each word holds its own address.
  always @(posedge clk)
    for (int u = 0; u < 3; u++) begin
      d1[u] <= {12'b0, sa[u]};
      sd[u] <= d1[u];
    end
  lbm_stream_engine #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .DATA_W(16), .DX(1), .DY(0),
    .RD_LAT(2), .WRAP_X(1), .WRAP_Y(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .barriers(bar[0]), .busy(bz[0]), .done(dn[0]),
    .src_addr(sa[0]), .src_rd_en(ren[0]), .src_data(sd[0]), .dst_addr(da[0]), .dst_data(dd[0]),
    .dst_we(dw[0]), .refl_addr(ra[0]), .refl_data(rd[0]), .refl_we(rw[0]),
    .cells_written(cw[0]), .cells_reflected(cr[0]));
  lbm_stream_engine #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .DATA_W(16), .DX(1), .DY(0),
    .RD_LAT(2), .WRAP_X(0), .WRAP_Y(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .barriers(bar[1]), .busy(bz[1]), .done(dn[1]),
    .src_addr(sa[1]), .src_rd_en(ren[1]), .src_data(sd[1]), .dst_addr(da[1]), .dst_data(dd[1]),
    .dst_we(dw[1]), .refl_addr(ra[1]), .refl_data(rd[1]), .refl_we(rw[1]),
    .cells_written(cw[1]), .cells_reflected(cr[1]));
  lbm_stream_engine #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .DATA_W(16), .DX(0), .DY(-1),
    .RD_LAT(2), .WRAP_X(1), .WRAP_Y(0)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .barriers(bar[2]), .busy(bz[2]), .done(dn[2]),
    .src_addr(sa[2]), .src_rd_en(ren[2]), .src_data(sd[2]), .dst_addr(da[2]), .dst_data(dd[2]),
    .dst_we(dw[2]), .refl_addr(ra[2]), .refl_data(rd[2]), .refl_we(rw[2]),
    .cells_written(cw[2]), .cells_reflected(cr[2]));
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  // Starts a pass on unit u at edge 0 and logs 30 cycles; optionally re-pulses start or asserts reset at a given edge.
  task automatic pass(input int u, input int again, input int kill);
    dhit = '0;
    rhit = '0;
    nw = 0;
    ndone = 0;
    tdone = -1;
    tw0 = -1;
    both = 0;
    for (int a = 0; a < 16; a++) begin
      dmem[a] = 16'hffff;
      rmem[a] = 16'hffff;
    end
    st[u] = 1'b1;
    @(negedge clk);
    st[u] = 1'b0;
    b0 = int'(bz[u]);
    for (int n = 1; n <= 30; n++) begin
      st[u] = (n == again);
      rst = (n != kill);
      @(negedge clk);
      if (n == 1) begin
        r1_en = int'(ren[u]);
        r1_addr = int'(sa[u]);
      end
      if (n == kill) begin
        chk("kill_busy", bz[u], 0);
        chk("kill_dst_we", dw[u], 0);
        chk("kill_refl_we", rw[u], 0);
        chk("kill_cw", cw[u], 0);
        chk("kill_cr", cr[u], 0);
      end
      if (dw[u]) begin
        dhit[da[u]] = 1'b1;
        dmem[da[u]] = dd[u];
        nw++;
        if (tw0 < 0) tw0 = n;
      end
      if (rw[u]) begin
        rhit[ra[u]] = 1'b1;
        rmem[ra[u]] = rd[u];
        nw++;
      end
      if (dw[u] && rw[u]) both++;
      if (dn[u]) begin
        ndone++;
        tdone = n;
      end
    end
    st[u] = 1'b0;
    rst = 1'b1;
  endtask
  initial begin
    for (int u = 0; u < 3; u++) begin
      st[u] = 1'b0;
      bar[u] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_rd_en", ren[0], 0);
    chk("rst_src_addr", sa[0], 0);
    chk("rst_dst_we", dw[0], 0);
    chk("rst_refl_we", rw[0], 0);
    chk("rst_cw", cw[0], 0);
    rst = 1'b1;
    @(negedge clk);
    pass(0, -1, -1);
    chk("wrap_busy0", b0, 1);
    chk("wrap_rd1_en", r1_en, 1);
    chk("wrap_rd1_addr", r1_addr, 0);
    chk("wrap_first_wr", tw0, 4);
    chk("wrap_done_cyc", tdone, 16);
    chk("wrap_done_n", ndone, 1);
    chk("wrap_cw", cw[0], 12);
    chk("wrap_cr", cr[0], 0);
    chk("wrap_hits", dhit, 16'h0fff);
    chk("wrap_a1", dmem[1], 0);
    chk("wrap_a0", dmem[0], 3);
    chk("wrap_a4", dmem[4], 7);
    chk("wrap_idle", bz[0], 0);
    pass(1, -1, -1);
    chk("dropx_cw", cw[1], 9);
    chk("dropx_nw", nw, 9);
    chk("dropx_hits", dhit, 16'h0eee);
    chk("dropx_a1", dmem[1], 0);
    chk("dropx_a5", dmem[5], 4);
    chk("dropx_done_cyc", tdone, 16);
    bar[0] = 12'h004;
    pass(0, -1, -1);
    chk("bb_cw", cw[0], 10);
    chk("bb_cr", cr[0], 1);
    chk("bb_rhits", rhit, 16'h0002);
    chk("bb_r1", rmem[1], 1);
    chk("bb_hits", dhit, 16'h0ff3);
    chk("bb_both", both, 0);
    bar[0] = '0;
    pass(2, -1, -1);
    chk("dropy_cw", cw[2], 8);
    chk("dropy_hits", dhit, 16'h00ff);
    chk("dropy_a1", dmem[1], 5);
    chk("dropy_a0", dmem[0], 4);
    chk("dropy_done_cyc", tdone, 16);
    pass(0, 5, -1);
    chk("restart_done_n", ndone, 1);
    chk("restart_done_cyc", tdone, 16);
    chk("restart_cw", cw[0], 12);
    chk("restart_nw", nw, 12);
    pass(0, -1, 6);
    chk("kill_nw", nw, 2);
    chk("kill_done_n", ndone, 0);
    pass(0, -1, -1);
    chk("after_cw", cw[0], 12);
    chk("after_done_cyc", tdone, 16);
    chk("after_hits", dhit, 16'h0fff);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
